// File: rtl/upbus_if.sv
// Config-register bus bundle between the host bridge, upbus_master and the
// bank of register slaves. The master modport is the initiator; the slave
// modport is the far side (host requests plus slave read-back/parity lines).
interface upbus_if #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int NREG = 8
);
    logic                 req_vld;
    logic                 req_rdy;
    logic                 req_wr;
    logic [AW-1:0]        req_addr;
    logic [DW-1:0]        req_wdata;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [NREG-1:0]      upen;
    logic                 upws;
    logic [DW-1:0]        updi;
    logic [NREG*DW-1:0]   updo_bus;
    logic [NREG-1:0]      par_err_bus;

    modport master (
        input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy, updo_bus, par_err_bus,
        output req_rdy, rsp_vld, rsp_rdata, rsp_err, upen, upws, updi
    );

    modport slave (
        output req_vld, req_wr, req_addr, req_wdata, rsp_rdy, updo_bus, par_err_bus,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_err, upen, upws, updi
    );
endinterface

// File: rtl/upbus_master.sv
// Initiator for the config-register bus. Takes one host request at a time,
// decodes the register index to a one-hot upen, strobes writes with upws/updi,
// captures the wired-OR of slave updo for reads and answers with data + error.
// Optional parity checking is compiled in with the macro UPBUS_PARCHK_EN,
// which also adds the par_err_sticky status output.
module upbus_master #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int NREG   = 8,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_,
    upbus_if.master     bus
`ifdef UPBUS_PARCHK_EN
    ,
    output logic        par_err_sticky
`endif
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    // NREG may equal 2^AW, so the decode limit needs one extra bit.
    localparam logic [AW:0]      NREG_LIM = (AW+1)'(NREG);
    localparam logic [3:0]       RD_LAST  = 4'(RD_LAT - 1);
    localparam logic [NREG-1:0]  EN_ONE   = NREG'(1);

    state_t          state;
    logic [3:0]      rd_cnt;
    logic            rsp_vld_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;
    logic [NREG-1:0] upen_q;
    logic            upws_q;
    logic [DW-1:0]   updi_q;
    logic [DW-1:0]   rd_or;
    logic            par_hit;

    assign bus.req_rdy   = (state == IDLE);
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.upen      = upen_q;
    assign bus.upws      = upws_q;
    assign bus.updi      = updi_q;

    // Wired-OR of all slave read-back slices; non-enabled slaves drive zero.
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NREG; i++) begin
            rd_or = rd_or | bus.updo_bus[i*DW +: DW];
        end
    end

`ifdef UPBUS_PARCHK_EN
    // upen is one-hot on the addressed slave during RD, so it selects its parity line.
    always_comb begin
        par_hit = |(upen_q & bus.par_err_bus);
    end
`else
    // Parity lines are not consulted in this build.
    logic unused_par;
    assign unused_par = ^bus.par_err_bus;
    always_comb begin
        par_hit = 1'b0;
    end
`endif

    // Request/response sequencer with all bus outputs registered.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            upen_q      <= '0;
            upws_q      <= 1'b0;
            updi_q      <= '0;
`ifdef UPBUS_PARCHK_EN
            par_err_sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_vld) begin
                        if ({1'b0, bus.req_addr} >= NREG_LIM) begin
                            // Out-of-range index: answer with an error, never touch the bus.
                            state       <= RESP;
                            rsp_vld_q   <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (bus.req_wr) begin
                            state  <= WR;
                            upen_q <= EN_ONE << bus.req_addr;
                            upws_q <= 1'b1;
                            updi_q <= bus.req_wdata;
                        end else begin
                            state  <= RD;
                            upen_q <= EN_ONE << bus.req_addr;
                            rd_cnt <= '0;
                        end
                    end
                end
                WR: begin
                    state       <= RESP;
                    upen_q      <= '0;
                    upws_q      <= 1'b0;
                    updi_q      <= '0;
                    rsp_vld_q   <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                RD: begin
                    if (rd_cnt == RD_LAST) begin
                        state       <= RESP;
                        upen_q      <= '0;
                        rsp_vld_q   <= 1'b1;
                        rsp_rdata_q <= rd_or;
                        rsp_err_q   <= par_hit;
`ifdef UPBUS_PARCHK_EN
                        par_err_sticky <= par_err_sticky | par_hit;
`endif
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_rdy) begin
                        state     <= IDLE;
                        rsp_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upbus_master.sv
// Bench for upbus_master: a driver issues directed then random requests and
// pushes the expected response into a queue; a negedge monitor pops and
// compares. Register contents are modelled as a plain array in the bench.
// Build with UPBUS_PARCHK_EN to exercise parity reporting.
module tb_upbus_master;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int NREG   = 8;
    localparam int RD_LAT = 2;

    typedef struct {
        logic [DW-1:0]   rdata;
        logic [DW-1:0]   wdata;
        logic [NREG-1:0] en;
        bit              err;
        bit              par;
        int              lat;
        int              en_cyc;
        int              ws_cyc;
    } exp_t;

    logic clk;
    logic rst_;
`ifdef UPBUS_PARCHK_EN
    logic par_err_sticky;
`endif

    upbus_if #(.DW(DW), .AW(AW), .NREG(NREG)) ubus ();

    upbus_master #(.DW(DW), .AW(AW), .NREG(NREG), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (ubus)
`ifdef UPBUS_PARCHK_EN
        ,
        .par_err_sticky (par_err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t sb[$];

    logic [DW-1:0] ref_mem  [NREG];
    logic [DW-1:0] slv_mem  [NREG];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave bank: stores on upws, drives its value onto updo only when enabled.
    always @(posedge clk) begin
        if (ubus.upws) begin
            for (int i = 0; i < NREG; i++) begin
                if (ubus.upen[i]) slv_mem[i] <= ubus.updi;
            end
        end
    end

    always_comb begin
        ubus.updo_bus = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ubus.upen[i]) ubus.updo_bus[i*DW +: DW] = slv_mem[i];
        end
    end

    // ---------------- monitor ----------------
    bit            busy = 0;
    bit            seen_vld;
    bit            hold_v = 0;
    logic [DW-1:0] hold_rd;
    logic          hold_err;
    int            cyc, en_cnt, ws_cnt;
    bit            exp_sticky = 0;
    exp_t          cur;

    always @(negedge clk) begin
        if (!rst_) begin
            chk("rst_req_rdy", 32'(ubus.req_rdy), 32'd1);
            chk("rst_rsp_vld", 32'(ubus.rsp_vld), 32'd0);
            chk("rst_upen", 32'(ubus.upen), 32'd0);
            chk("rst_upws", 32'(ubus.upws), 32'd0);
            sb.delete();
            busy       = 0;
            hold_v     = 0;
            exp_sticky = 0;
        end else begin
            chk("req_rdy", 32'(ubus.req_rdy), 32'(!busy));
            if (!busy) begin
                chk("idle_rsp_vld", 32'(ubus.rsp_vld), 32'd0);
                chk("idle_upen", 32'(ubus.upen), 32'd0);
                chk("idle_upws", 32'(ubus.upws), 32'd0);
                if (ubus.req_vld && ubus.req_rdy) begin
                    if (sb.size() == 0) begin
                        chk("accept_without_expectation", 32'd1, 32'd0);
                    end else begin
                        cur      = sb[0];
                        busy     = 1;
                        cyc      = 0;
                        en_cnt   = 0;
                        ws_cnt   = 0;
                        seen_vld = 0;
                    end
                end
            end else begin
                cyc++;
                if (hold_v) begin
                    chk("hold_rsp_vld", 32'(ubus.rsp_vld), 32'd1);
                    chk("hold_rdata", 32'(ubus.rsp_rdata), 32'(hold_rd));
                    chk("hold_err", 32'(ubus.rsp_err), 32'(hold_err));
                    hold_v = 0;
                end
                if (ubus.upen != '0) begin
                    en_cnt++;
                    chk("upen_value", 32'(ubus.upen), 32'(cur.en));
                end
                if (ubus.upws) begin
                    ws_cnt++;
                    chk("updi_value", 32'(ubus.updi), 32'(cur.wdata));
                end
                if (ubus.rsp_vld && !seen_vld) begin
                    seen_vld = 1;
                    chk("rsp_latency", 32'(cyc), 32'(cur.lat));
                    chk("upen_cycles", 32'(en_cnt), 32'(cur.en_cyc));
                    chk("upws_cycles", 32'(ws_cnt), 32'(cur.ws_cyc));
                    exp_sticky = exp_sticky | cur.par;
                end
                if (ubus.rsp_vld && !ubus.rsp_rdy) begin
                    hold_v   = 1;
                    hold_rd  = ubus.rsp_rdata;
                    hold_err = ubus.rsp_err;
                end
                if (ubus.rsp_vld && ubus.rsp_rdy) begin
                    chk("rsp_rdata", 32'(ubus.rsp_rdata), 32'(cur.rdata));
                    chk("rsp_err", 32'(ubus.rsp_err), 32'(cur.err));
                    void'(sb.pop_front());
                    busy = 0;
                end
            end
        end
`ifdef UPBUS_PARCHK_EN
        chk("par_err_sticky", 32'(par_err_sticky), 32'(exp_sticky));
`endif
    end

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        ubus.req_vld   = 1'($urandom);
        ubus.req_wr    = 1'($urandom);
        ubus.req_addr  = AW'($urandom);
        ubus.req_wdata = DW'($urandom);
    endtask

    // hold < 0: random rsp_rdy; 0: always ready; >0: ready only after rsp_vld was seen hold+1 times.
    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit pe, input int hold);
        exp_t            e;
        logic [NREG-1:0] pv;
        int              t;
        int              vcnt;
        t = 0;
        while (!ubus.req_rdy && t < 60) begin
            cycle();
            t++;
        end
        if (t >= 60) chk("wait_req_rdy_timeout", 32'd1, 32'd0);
        pv = NREG'($urandom);
        if (int'(a) < NREG) pv[a] = pe;
        ubus.par_err_bus = pv;

        e.wdata  = d;
        e.en     = '0;
        e.par    = 0;
        e.rdata  = '0;
        e.ws_cyc = 0;
        e.en_cyc = 0;
        if (int'(a) >= NREG) begin
            e.err = 1;
            e.lat = 1;
        end else begin
            e.en = NREG'(1) << a;
            if (wr) begin
                e.err      = 0;
                e.lat      = 2;
                e.en_cyc   = 1;
                e.ws_cyc   = 1;
                ref_mem[a] = d;
            end else begin
`ifdef UPBUS_PARCHK_EN
                e.par = pe;
`endif
                e.err    = e.par;
                e.lat    = 1 + RD_LAT;
                e.en_cyc = RD_LAT;
                e.rdata  = ref_mem[a];
            end
        end
        sb.push_back(e);

        ubus.req_vld   = 1'b1;
        ubus.req_wr    = wr;
        ubus.req_addr  = a;
        ubus.req_wdata = d;
        ubus.rsp_rdy   = (hold == 0) ? 1'b1 : 1'($urandom);
        cycle();
        t    = 0;
        vcnt = 0;
        while (!ubus.req_rdy && t < 60) begin
            junk();
            if (ubus.rsp_vld) vcnt++;
            if (hold == 0)     ubus.rsp_rdy = 1'b1;
            else if (hold > 0) ubus.rsp_rdy = (vcnt > hold);
            else               ubus.rsp_rdy = ($urandom_range(0, 2) != 0);
            cycle();
            t++;
        end
        if (t >= 60) chk("wait_rsp_timeout", 32'd1, 32'd0);
        ubus.req_vld = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        rst_             = 1'b0;
        ubus.req_vld     = 1'b0;
        ubus.req_wr      = 1'b0;
        ubus.req_addr    = '0;
        ubus.req_wdata   = '0;
        ubus.rsp_rdy     = 1'b0;
        ubus.par_err_bus = '0;
        repeat (3) cycle();
        rst_ = 1'b1;
        repeat (2) cycle();

        // Directed cases
        do_req(1'b1, 4'd2, 8'hA5, 1'b0, 0);
        do_req(1'b1, 4'd5, 8'h3C, 1'b0, 0);
        do_req(1'b0, 4'd5, 8'h00, 1'b0, 0);
        do_req(1'b0, 4'd9, 8'h00, 1'b0, 0);
        do_req(1'b1, 4'd15, 8'h77, 1'b0, 0);
        do_req(1'b0, 4'd2, 8'h00, 1'b0, 3);
        do_req(1'b1, 4'd1, 8'h5A, 1'b0, 0);
        do_req(1'b0, 4'd1, 8'h00, 1'b1, 0);
        do_req(1'b0, 4'd5, 8'h00, 1'b0, 0);
        do_req(1'b0, 4'd7, 8'h00, 1'b0, 0);

        // Reset during the first RD cycle aborts the read without a response
        ubus.par_err_bus = '0;
        sb.push_back('{rdata: '0, wdata: '0, en: 8'h08, err: 0, par: 0,
                       lat: 1 + RD_LAT, en_cyc: RD_LAT, ws_cyc: 0});
        ubus.req_vld  = 1'b1;
        ubus.req_wr   = 1'b0;
        ubus.req_addr = 4'd3;
        ubus.rsp_rdy  = 1'b1;
        cycle();
        ubus.req_vld = 1'b0;
        chk("rd_started_upen", 32'(ubus.upen), 32'h08);
        rst_ = 1'b0;
        #1;
        chk("abort_upen", 32'(ubus.upen), 32'd0);
        chk("abort_upws", 32'(ubus.upws), 32'd0);
        chk("abort_rsp_vld", 32'(ubus.rsp_vld), 32'd0);
        chk("abort_req_rdy", 32'(ubus.req_rdy), 32'd1);
        repeat (2) cycle();
        rst_ = 1'b1;
        repeat (6) cycle();

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 4) == 0) a = AW'($urandom_range(NREG, (1 << AW) - 1));
            else                           a = AW'($urandom_range(0, NREG - 1));
            do_req(1'($urandom), a, DW'($urandom), ($urandom_range(0, 3) == 0), -1);
            repeat ($urandom_range(0, 2)) cycle();
        end
        repeat (4) cycle();
        chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
